// File: rtl/line_commit_ctrl.sv
// line_commit_ctrl: commits each completed PPU scanline into the display
// line RAM as four plane writes at address {plane, LY}. It holds one line in
// flight plus one pending line; any further line is dropped and flagged.
// Optional macro LINE_DROP_COUNT_EN enables the saturating dropCount output.
module line_commit_ctrl #(
  parameter int LINES = 144
) (
  input  logic         pixelClk,
  input  logic         reset,
  input  logic [7:0]   LY,
  input  logic         updateBufferSignal,
  input  logic [159:0] LineBuffer0,
  input  logic [159:0] LineBuffer1,
  input  logic [159:0] LineBuffer2,
  input  logic [159:0] LineBuffer3,
  output logic [9:0]   ramAddr,
  output logic [159:0] ramData,
  output logic         ramWe,
  output logic         busy,
  output logic         overflow,
  output logic         frameStart,
  output logic [7:0]   dropCount
);

  localparam int         PLANES     = 4;
  localparam logic [1:0] LAST_PLANE = 2'(PLANES - 1);
  localparam logic [8:0] LINES_W    = 9'(LINES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   plane_q, plane_d;
  logic [639:0] work_q, work_d;
  logic [7:0]   work_ly_q, work_ly_d;
  logic [639:0] pend_q, pend_d;
  logic [7:0]   pend_ly_q, pend_ly_d;
  logic         pend_valid_q, pend_valid_d;
  logic [7:0]   last_ly_q, last_ly_d;
  logic [9:0]   ram_addr_q, ram_addr_d;
  logic [159:0] ram_data_q, ram_data_d;
  logic         ram_we_q, ram_we_d;
  logic         busy_q, busy_d;
  logic         overflow_q, overflow_d;
  logic         frame_start_q, frame_start_d;

  logic         trig_s;
  logic         vtrig_s;
  logic         accept_s;
  logic         drop_s;
  logic [639:0] lines_s;

  // Plane p of a packed four-plane snapshot.
  function automatic logic [159:0] plane_word(input logic [639:0] w, input logic [1:0] p);
    case (p)
      2'd0:    plane_word = w[159:0];
      2'd1:    plane_word = w[319:160];
      2'd2:    plane_word = w[479:320];
      2'd3:    plane_word = w[639:480];
      default: plane_word = w[159:0];
    endcase
  endfunction

  assign lines_s = {LineBuffer3, LineBuffer2, LineBuffer1, LineBuffer0};
  // A trigger is any LY change while the buffers hold a finished line.
  assign trig_s  = updateBufferSignal && (LY != last_ly_q);
  // Only visible lines get written; vblank lines just move the tracker.
  assign vtrig_s = trig_s && ({1'b0, LY} < LINES_W);

  // Next-state logic: line sequencing, pending slot and RAM write strobe.
  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    work_d       = work_q;
    work_ly_d    = work_ly_q;
    pend_d       = pend_q;
    pend_ly_d    = pend_ly_q;
    pend_valid_d = pend_valid_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    accept_s     = 1'b0;
    drop_s       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vtrig_s) begin
          work_d    = lines_s;
          work_ly_d = LY;
          plane_d   = 2'd0;
          state_d   = ST_WRITE;
          accept_s  = 1'b1;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_WRITE: begin
        ram_we_d   = 1'b1;
        ram_addr_d = {plane_q, work_ly_q};
        ram_data_d = plane_word(work_q, plane_q);
        plane_d    = plane_q + 2'd1;
        if (plane_q != LAST_PLANE) begin
          if (vtrig_s && !pend_valid_q) begin
            pend_d       = lines_s;
            pend_ly_d    = LY;
            pend_valid_d = 1'b1;
            accept_s     = 1'b1;
          end else if (vtrig_s) begin
            drop_s       = 1'b1;
          end else begin
            pend_valid_d = pend_valid_q;
          end
        end else if (pend_valid_q) begin
          // Pending line takes over with no idle gap; a same-cycle trigger
          // immediately refills the slot it frees.
          work_d    = pend_q;
          work_ly_d = pend_ly_q;
          plane_d   = 2'd0;
          if (vtrig_s) begin
            pend_d       = lines_s;
            pend_ly_d    = LY;
            pend_valid_d = 1'b1;
            accept_s     = 1'b1;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (vtrig_s) begin
          work_d    = lines_s;
          work_ly_d = LY;
          plane_d   = 2'd0;
          accept_s  = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          plane_d   = 2'd0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        plane_d      = 2'd0;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Status flags derived from the next state and this cycle's events.
  always_comb begin
    last_ly_d     = trig_s ? LY : last_ly_q;
    busy_d        = (state_d == ST_WRITE) || pend_valid_d;
    overflow_d    = overflow_q || drop_s;
    frame_start_d = accept_s && (LY == 8'd0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      plane_q       <= 2'd0;
      work_q        <= 640'd0;
      work_ly_q     <= 8'd0;
      pend_q        <= 640'd0;
      pend_ly_q     <= 8'd0;
      pend_valid_q  <= 1'b0;
      last_ly_q     <= 8'hFF;
      ram_addr_q    <= 10'd0;
      ram_data_q    <= 160'd0;
      ram_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      plane_q       <= plane_d;
      work_q        <= work_d;
      work_ly_q     <= work_ly_d;
      pend_q        <= pend_d;
      pend_ly_q     <= pend_ly_d;
      pend_valid_q  <= pend_valid_d;
      last_ly_q     <= last_ly_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      ram_we_q      <= ram_we_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LINE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of dropped lines.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if (drop_s && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign dropCount = drop_cnt_q;
`else
  assign dropCount = 8'h00;
`endif

  assign ramAddr    = ram_addr_q;
  assign ramData    = ram_data_q;
  assign ramWe      = ram_we_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign frameStart = frame_start_q;

endmodule

// File: tb/tb_line_commit_ctrl.sv
// Directed bench for line_commit_ctrl: write bursts, pending/drop handling,
// vblank lines and mid-burst reset, with hand-computed expected values.
module tb_line_commit_ctrl;

  logic         pixelClk;
  logic         reset;
  logic [7:0]   LY;
  logic         updateBufferSignal;
  logic [159:0] LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3;
  logic [9:0]   ramAddr;
  logic [159:0] ramData;
  logic         ramWe;
  logic         busy;
  logic         overflow;
  logic         frameStart;
  logic [7:0]   dropCount;

`ifdef LINE_DROP_COUNT_EN
  localparam logic [7:0] EXP_DROP = 8'h01;
`else
  localparam logic [7:0] EXP_DROP = 8'h00;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];

  line_commit_ctrl dut (
    .pixelClk(pixelClk), .reset(reset), .LY(LY),
    .updateBufferSignal(updateBufferSignal),
    .LineBuffer0(LineBuffer0), .LineBuffer1(LineBuffer1),
    .LineBuffer2(LineBuffer2), .LineBuffer3(LineBuffer3),
    .ramAddr(ramAddr), .ramData(ramData), .ramWe(ramWe), .busy(busy),
    .overflow(overflow), .frameStart(frameStart), .dropCount(dropCount)
  );

  initial pixelClk = 1'b0;
  always #5 pixelClk = ~pixelClk;

  function automatic logic [159:0] pat(input logic [7:0] ly, input logic [3:0] p);
    pat = {10{ly, p, 4'hC}};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic [7:0] ly);
    LY          = ly;
    LineBuffer0 = pat(ly, 4'd0);
    LineBuffer1 = pat(ly, 4'd1);
    LineBuffer2 = pat(ly, 4'd2);
    LineBuffer3 = pat(ly, 4'd3);
  endtask

  // One clock; sample 1 time unit after the edge and log {ramWe, ramAddr}.
  task automatic step();
    @(posedge pixelClk);
    #1;
    log_q.push_back(ramWe ? {1'b1, ramAddr} : 11'h000);
  endtask

  task automatic ex(input logic [10:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 160'(log_q.size()), 160'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 160'(log_q[i]), 160'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    updateBufferSignal = 1'b0;
    set_line(8'd0);

    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_addr", 160'(ramAddr), 160'd0);
    chk("rst_data", ramData, 160'd0);
    chk("rst_we", 160'(ramWe), 160'd0);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_ovf", 160'(overflow), 160'd0);
    chk("rst_fs", 160'(frameStart), 160'd0);
    chk("rst_drop", 160'(dropCount), 160'd0);

    // Line 0 burst; buffers scrambled after the trigger to prove the snapshot
    updateBufferSignal = 1'b1;
    step();
    chk("l0_fs", 160'(frameStart), 160'd1);
    chk("l0_we0", 160'(ramWe), 160'd0);
    chk("l0_busy", 160'(busy), 160'd1);
    LineBuffer0 = ~pat(8'd0, 4'd0);
    LineBuffer1 = ~pat(8'd0, 4'd1);
    LineBuffer2 = ~pat(8'd0, 4'd2);
    LineBuffer3 = ~pat(8'd0, 4'd3);
    for (int p = 0; p < 4; p++) begin
      step();
      chk($sformatf("l0_we_p%0d", p), 160'(ramWe), 160'd1);
      chk($sformatf("l0_addr_p%0d", p), 160'(ramAddr), 160'({2'(p), 8'd0}));
      chk($sformatf("l0_data_p%0d", p), ramData, pat(8'd0, 4'(p)));
    end
    chk("l0_fs_off", 160'(frameStart), 160'd0);
    chk("l0_busy_end", 160'(busy), 160'd0);
    step();
    chk("l0_we_end", 160'(ramWe), 160'd0);
    log_q.delete();

    // LY=5 held for 20 cycles: one burst only
    set_line(8'd5);
    repeat (20) step();
    ex(11'h000); ex(11'h405); ex(11'h505); ex(11'h605); ex(11'h705);
    repeat (15) ex(11'h000);
    check_log("hold5");

    // LY=20, then LY=21 sampled on the plane-3 cycle: 8 contiguous writes
    set_line(8'd20);
    step(); step(); step(); step();
    set_line(8'd21);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 3) chk("b2b_data21_p3", ramData, pat(8'd21, 4'd3));
    end
    ex(11'h000); ex(11'h414); ex(11'h514); ex(11'h614); ex(11'h714);
    ex(11'h415); ex(11'h515); ex(11'h615); ex(11'h715); ex(11'h000);
    check_log("b2b");
    chk("b2b_ovf", 160'(overflow), 160'd0);

    // Vblank lines 144 and 153 write nothing; then LY=0 starts a frame
    set_line(8'd144);
    step();
    set_line(8'd153);
    step();
    chk("vbl_busy", 160'(busy), 160'd0);
    step();
    set_line(8'd0);
    step();
    chk("vbl_fs", 160'(frameStart), 160'd1);
    repeat (5) step();
    ex(11'h000); ex(11'h000); ex(11'h000); ex(11'h000);
    ex(11'h400); ex(11'h500); ex(11'h600); ex(11'h700); ex(11'h000);
    check_log("vbl");

    // LY 10 -> 11 -> 12: 10 written, 11 pending then written, 12 dropped
    set_line(8'd10);
    step();
    set_line(8'd11);
    step();
    set_line(8'd12);
    step();
    chk("drop_ovf", 160'(overflow), 160'd1);
    chk("drop_cnt", 160'(dropCount), 160'(EXP_DROP));
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) chk("drop_data11_p0", ramData, pat(8'd11, 4'd0));
    end
    ex(11'h000); ex(11'h40A); ex(11'h50A); ex(11'h60A); ex(11'h70A);
    ex(11'h40B); ex(11'h50B); ex(11'h60B); ex(11'h70B); ex(11'h000); ex(11'h000);
    check_log("drop");
    chk("drop_ovf_sticky", 160'(overflow), 160'd1);

    // Reset while plane 1 is in flight with line 31 pending
    set_line(8'd30);
    step();
    set_line(8'd31);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_we", 160'(ramWe), 160'd0);
    chk("mrst_busy", 160'(busy), 160'd0);
    chk("mrst_addr", 160'(ramAddr), 160'd0);
    chk("mrst_ovf", 160'(overflow), 160'd0);
    chk("mrst_drop", 160'(dropCount), 160'd0);
    updateBufferSignal = 1'b0;
    repeat (6) step();
    updateBufferSignal = 1'b1;
    set_line(8'd0);
    step();
    chk("mrst_fs", 160'(frameStart), 160'd1);
    repeat (4) step();
    chk("mrst_data_p3", ramData, pat(8'd0, 4'd3));
    ex(11'h000); ex(11'h41E); ex(11'h000);
    repeat (6) ex(11'h000);
    ex(11'h000); ex(11'h400); ex(11'h500); ex(11'h600); ex(11'h700);
    check_log("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
